seq_83_encoder: RTL



---
 rtl/seq_83_encoder.sv | 73 +++++++
 1 files changed

// File: rtl/seq_83_encoder.sv
// Sequential 8-to-3 encoder: loads a multi-hot register-select vector and
// emits its set bit positions one per handshake, lowest index first.
module seq_83_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] idx,
    output logic       idx_valid,
    input  logic       idx_ready,
    output logic       idx_last,
    output logic [3:0] count
);

    logic [7:0] pending_r;
    logic [7:0] pending_next_s;
    logic [7:0] clear_mask_s;
    logic       accept_s;
    logic       drain_s;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Scanning downward lets the lowest set bit overwrite any higher one.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

    assign idx_valid    = |pending_r;
    assign idx          = lowest_index(pending_r);
    assign count        = popcount8(pending_r);
    assign idx_last     = (count == 4'd1);
    assign req_ready    = (pending_r == 8'h00) | (idx_valid & idx_ready & idx_last);
    assign accept_s     = req_valid & req_ready;
    assign drain_s      = idx_valid & idx_ready;
    assign clear_mask_s = 8'h01 << idx;

    // Next pending set: a load replaces the set outright, so it also wins over a final drain.
    always_comb begin
        pending_next_s = pending_r;
        if (accept_s) begin
            pending_next_s = req;
        end else if (drain_s) begin
            pending_next_s = pending_r & ~clear_mask_s;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Pending set register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 8'h00;
        end else begin
            pending_r <= pending_next_s;
        end
    end

endmodule
